// File: rtl/cnt_seq_checker.sv
// rtl/cnt_seq_checker.sv - counter sequence checker with acquire/lock tracking and error counting
//
// Watches a counter under test and checks that each valid sample equals the
// previous valid sample plus STEP (modulo 2^WIDTH).
//   IDLE : first valid sample only seeds the expectation.
//   ACQ  : LOCK_CNT consecutive matches are needed to enter LOCK.
//   LOCK : a mismatch raises err_pulse, bumps err_cnt and drops back to ACQ.
// Every valid sample re-seeds the expectation from the observed value.
//
// Optional feature macro: CNT_SEQ_CHECKER_STICKY_EN
//   defined   : err_sticky sets with any err_pulse and holds until RST.
//   undefined : err_sticky is tied to 0 and no register is built.
//
// Ports:
//   CLK        in   clock, rising edge
//   RST        in   synchronous active-high reset
//   cnt_in     in   observed counter value [WIDTH]
//   cnt_vld    in   cnt_in is sampled on this edge when high
//   clr_err    in   clears err_cnt
//   locked     out  checker is in LOCK
//   err_pulse  out  one-cycle pulse per sequence error in LOCK
//   err_cnt    out  saturating error count [WIDTH]
//   last_good  out  most recent matching sample [WIDTH]
//   err_sticky out  sticky fault flag
module cnt_seq_checker #(
    parameter int WIDTH    = 8,
    parameter int STEP     = 1,
    parameter int LOCK_CNT = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] cnt_in,
    input  logic             cnt_vld,
    input  logic             clr_err,
    output logic             locked,
    output logic             err_pulse,
    output logic [WIDTH-1:0] err_cnt,
    output logic [WIDTH-1:0] last_good,
    output logic             err_sticky
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACQ  = 2'd1,
        S_LOCK = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] STEP_W     = WIDTH'(STEP);
    localparam logic [3:0]       LOCK_CNT_W = 4'(LOCK_CNT);
    localparam logic [WIDTH-1:0] ONE_W      = WIDTH'(1);
    localparam logic [WIDTH-1:0] SAT_W      = {WIDTH{1'b1}};

    state_t           state_q, state_d;
    logic [3:0]       run_q, run_d;
    logic [WIDTH-1:0] expected_q, expected_d;
    logic             locked_q, locked_d;
    logic             err_pulse_q, err_pulse_d;
    logic [WIDTH-1:0] err_cnt_q, err_cnt_d;
    logic [WIDTH-1:0] last_good_q, last_good_d;
    logic             match;
    logic [3:0]       run_inc;

    assign match   = (cnt_in == expected_q);
    assign run_inc = run_q + 4'd1;

    always_comb begin
        state_d     = state_q;
        run_d       = run_q;
        expected_d  = expected_q;
        locked_d    = locked_q;
        err_pulse_d = 1'b0;
        last_good_d = last_good_q;

        if (cnt_vld) begin
            // Resynchronise on whatever was observed, match or not.
            expected_d = cnt_in + STEP_W;
            case (state_q)
                S_IDLE: begin
                    run_d   = 4'd0;
                    state_d = S_ACQ;
                end
                S_ACQ: begin
                    if (match) begin
                        run_d       = run_inc;
                        last_good_d = cnt_in;
                        if (run_inc == LOCK_CNT_W) begin
                            state_d  = S_LOCK;
                            locked_d = 1'b1;
                        end
                    end else begin
                        run_d = 4'd0;
                    end
                end
                S_LOCK: begin
                    if (match) begin
                        last_good_d = cnt_in;
                    end else begin
                        err_pulse_d = 1'b1;
                        locked_d    = 1'b0;
                        run_d       = 4'd0;
                        state_d     = S_ACQ;
                    end
                end
                default: begin
                    state_d  = S_IDLE;
                    run_d    = 4'd0;
                    locked_d = 1'b0;
                end
            endcase
        end

        // A clear that coincides with a new error leaves that error counted.
        err_cnt_d = err_cnt_q;
        if (clr_err) begin
            err_cnt_d = err_pulse_d ? ONE_W : '0;
        end else if (err_pulse_d && (err_cnt_q != SAT_W)) begin
            err_cnt_d = err_cnt_q + ONE_W;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= S_IDLE;
            run_q       <= 4'd0;
            expected_q  <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            err_cnt_q   <= '0;
            last_good_q <= '0;
        end else begin
            state_q     <= state_d;
            run_q       <= run_d;
            expected_q  <= expected_d;
            locked_q    <= locked_d;
            err_pulse_q <= err_pulse_d;
            err_cnt_q   <= err_cnt_d;
            last_good_q <= last_good_d;
        end
    end

    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;
    assign err_cnt   = err_cnt_q;
    assign last_good = last_good_q;

`ifdef CNT_SEQ_CHECKER_STICKY_EN
    logic err_sticky_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            err_sticky_q <= 1'b0;
        end else if (err_pulse_d) begin
            err_sticky_q <= 1'b1;
        end
    end

    assign err_sticky = err_sticky_q;
`else
    assign err_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_cnt_seq_checker.sv
// tb/tb_cnt_seq_checker.sv - scoreboard bench for cnt_seq_checker
module tb_cnt_seq_checker;

    localparam int W    = 8;
    localparam int MASK = (1 << W) - 1;
    localparam int STP  = 1;
    localparam int LCNT = 4;

    logic         CLK = 1'b0;
    logic         RST;
    logic [W-1:0] cnt_in;
    logic         cnt_vld;
    logic         clr_err;
    logic         locked;
    logic         err_pulse;
    logic [W-1:0] err_cnt;
    logic [W-1:0] last_good;
    logic         err_sticky;

    cnt_seq_checker #(.WIDTH(W), .STEP(STP), .LOCK_CNT(LCNT)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .cnt_in    (cnt_in),
        .cnt_vld   (cnt_vld),
        .clr_err   (clr_err),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_cnt   (err_cnt),
        .last_good (last_good),
        .err_sticky(err_sticky)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int lk;
        int pl;
        int ec;
        int lg;
        int st;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

`ifdef CNT_SEQ_CHECKER_STICKY_EN
    localparam int STICKY_ON = 1;
`else
    localparam int STICKY_ON = 0;
`endif

    // Reference model: "have_ref" = a previous valid sample exists,
    // "streak" = consecutive matches since acquisition began.
    int m_have, m_streak, m_exp, m_lk, m_pl, m_ec, m_lg, m_st;

    task automatic model_edge(input int rst, input int vld, input int cnt, input int clr);
        if (rst != 0) begin
            m_have = 0; m_streak = 0; m_exp = 0; m_lk = 0;
            m_pl = 0; m_ec = 0; m_lg = 0; m_st = 0;
            return;
        end
        m_pl = 0;
        if (vld != 0) begin
            if (m_have == 0) begin
                m_have   = 1;
                m_streak = 0;
            end else if (cnt == m_exp) begin
                m_lg = cnt;
                if (m_lk == 0) begin
                    m_streak++;
                    if (m_streak == LCNT) m_lk = 1;
                end
            end else begin
                if (m_lk != 0) m_pl = 1;
                m_lk     = 0;
                m_streak = 0;
            end
            m_exp = (cnt + STP) & MASK;
        end
        if (clr != 0) m_ec = m_pl;
        else if (m_pl != 0 && m_ec < MASK) m_ec++;
        if (m_pl != 0 && STICKY_ON != 0) m_st = 1;
    endtask

    task automatic cyc(input int rst, input int vld, input int cnt, input int clr);
        exp_t e;
        RST     = (rst != 0);
        cnt_vld = (vld != 0);
        cnt_in  = W'(cnt);
        clr_err = (clr != 0);
        @(posedge CLK);
        model_edge(rst, vld, cnt & MASK, clr);
        e.lk = m_lk; e.pl = m_pl; e.ec = m_ec; e.lg = m_lg; e.st = m_st;
        exp_q.push_back(e);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    // Feed a run of consecutive values starting at v, n samples.
    task automatic run_seq(input int v, input int n);
        for (int i = 0; i < n; i++) cyc(0, 1, (v + i) & MASK, 0);
    endtask

    // Monitor: every edge produces a registered output set.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_checks++;
                if (int'(locked) != e.lk || int'(err_pulse) != e.pl || int'(err_cnt) != e.ec ||
                    int'(last_good) != e.lg || int'(err_sticky) != e.st) begin
                    n_fail++;
                    $display("FAIL scoreboard @%0t: got lk=%0d pl=%0d ec=0x%0h lg=0x%0h st=%0d required lk=%0d pl=%0d ec=0x%0h lg=0x%0h st=%0d",
                             $time, locked, err_pulse, err_cnt, last_good, err_sticky,
                             e.lk, e.pl, e.ec, e.lg, e.st);
                end
            end
        end
    end

    initial begin
        int cur;
        int r;
        RST = 1'b1; cnt_vld = 1'b0; cnt_in = '0; clr_err = 1'b0;

        // Reset for two cycles, then lock on 0x10..0x14.
        cyc(1, 0, 0, 0);
        cyc(1, 1, 8'h55, 1);
        chk("reset_locked", int'(locked), 0);
        chk("reset_err_cnt", int'(err_cnt), 0);
        chk("reset_last_good", int'(last_good), 0);
        run_seq(8'h10, 4);
        chk("acq_not_locked_yet", int'(locked), 0);
        cyc(0, 1, 8'h14, 0);
        chk("lock_after_0x14", int'(locked), 1);
        chk("lock_last_good", int'(last_good), 8'h14);
        chk("lock_err_cnt", int'(err_cnt), 0);

        // Wrap through 0xFF -> 0x00 while locked.
        cyc(1, 0, 0, 0);
        run_seq(8'hF8, 6);
        run_seq(8'hFE, 4);
        chk("wrap_locked", int'(locked), 1);
        chk("wrap_no_pulse", int'(err_pulse), 0);
        chk("wrap_last_good", int'(last_good), 8'h01);

        // Gap of three idle cycles, then the next value.
        for (int i = 0; i < 3; i++) cyc(0, 0, $urandom_range(0, 255), 0);
        chk("gap_hold_lg", int'(last_good), 8'h01);
        cyc(0, 1, 8'h02, 0);
        chk("gap_no_err", int'(err_cnt), 0);
        chk("gap_still_locked", int'(locked), 1);

        // Error in LOCK then relock.
        cyc(1, 0, 0, 0);
        run_seq(8'h1B, 6);
        cyc(0, 1, 8'h25, 0);
        chk("err_pulse", int'(err_pulse), 1);
        chk("err_cnt_1", int'(err_cnt), 1);
        chk("err_unlock", int'(locked), 0);
        run_seq(8'h26, 3);
        chk("err_pulse_single", int'(err_pulse), 0);
        cyc(0, 1, 8'h29, 0);
        chk("relock_0x29", int'(locked), 1);

        // 300 errors saturate err_cnt.
        cur = 8'h29;
        for (int k = 0; k < 300; k++) begin
            cur = (cur + 7) & MASK;
            cyc(0, 1, cur, 0);
            run_seq((cur + 1) & MASK, LCNT);
            cur = (cur + LCNT) & MASK;
        end
        chk("err_cnt_sat", int'(err_cnt), 8'hFF);
        cur = (cur + 9) & MASK;
        cyc(0, 1, cur, 1);
        chk("clr_with_err", int'(err_cnt), 1);
        chk("clr_with_err_pulse", int'(err_pulse), 1);
        chk("sticky_after_clr", int'(err_sticky), STICKY_ON);

        // Reset mid-LOCK discards progress.
        run_seq((cur + 1) & MASK, LCNT);
        chk("pre_rst_locked", int'(locked), 1);
        cyc(1, 1, 8'h40, 0);
        chk("rst_locked", int'(locked), 0);
        chk("rst_err_cnt", int'(err_cnt), 0);
        chk("rst_last_good", int'(last_good), 0);
        chk("rst_sticky", int'(err_sticky), 0);
        run_seq(8'h40, LCNT);
        chk("relock_needs_more", int'(locked), 0);
        cyc(0, 1, 8'h40 + LCNT, 0);
        chk("relock_after_1_plus_n", int'(locked), 1);

        // Randomised traffic against the model.
        cur = $urandom_range(0, 255);
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 99);
            if (r < 2) begin
                cyc(1, $urandom_range(0, 1), $urandom_range(0, 255), $urandom_range(0, 1));
            end else if (r < 15) begin
                cyc(0, 0, $urandom_range(0, 255), 0);
            end else begin
                if (r < 22) cur = $urandom_range(0, 255);
                else cur = (cur + STP) & MASK;
                cyc(0, 1, cur, ($urandom_range(0, 99) < 5) ? 1 : 0);
            end
        end

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge CLK);
        #1;
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: got %0d pending required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
